// File: rtl/synth_pkg.sv
// synth_pkg -- definitions shared by the synth PWM transmit stage and the
// PWM demodulator: frame geometry and the demodulator state encoding.
package synth_pkg;

    localparam int PWM_FRAME = 256;  // PWM frame length in clk cycles
    localparam int PWM_WIDTH = 8;    // sample width, PWM_FRAME = 2**PWM_WIDTH

    typedef enum logic [1:0] {
        HUNT = 2'd0,   // no frame timing known
        ACQ  = 2'd1,   // one boundary seen, waiting to confirm frame length
        LOCK = 2'd2    // frame length confirmed
    } demod_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge -- multi-flop synchronizer for an asynchronous 1-bit input with
// rising-edge detect on the synchronized level.
//   clk    : system clock
//   rst    : synchronous active-high clear of all flops
//   d_i    : asynchronous input
//   lvl_o  : synchronized level (last synchronizer stage)
//   rise_o : lvl_o is 1 this cycle and was 0 the previous cycle
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = lvl_o & ~prev_q;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod -- recovers WIDTH-bit samples from a 1-bit PWM stream in which
// every frame is FRAME cycles long and the line is high for `sample` cycles
// starting at the frame start.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   en       : block enable; low clears to HUNT (sample_o is held)
//   pwm_i    : asynchronous PWM line
//   sample_o : last recovered sample, held between strobes
//   valid_o  : one-cycle strobe, sample_o updated this cycle
//   locked_o : frame timing verified (registered copy of state==LOCK)
//   err_o    : one-cycle strobe on a framing violation
module pwm_demod
    import synth_pkg::*;
#(
    parameter int FRAME       = PWM_FRAME,
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_o
);

    // cnt_q counts cycles after the boundary cycle, so the cycle in which it
    // reads FRAME-1 is the FRAME-th cycle of the frame: a rise there closes
    // a correctly sized frame, and no rise there is a timeout.
    localparam logic [WIDTH:0] CNT_LAST = (WIDTH+1)'(FRAME - 1);
    localparam logic [WIDTH:0] HI_FULL  = (WIDTH+1)'(FRAME);

    logic         clr;
    logic         lvl, rise;
    demod_state_t state_q, state_d;
    logic [WIDTH:0] cnt_q, cnt_d;
    logic [WIDTH:0] hcnt_q, hcnt_d;
    logic         full, bnd, emit, err;

    assign clr = rst | ~en;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (clr),
        .d_i    (pwm_i),
        .lvl_o  (lvl),
        .rise_o (rise)
    );

    assign full = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        bnd     = 1'b0;
        emit    = 1'b0;
        err     = 1'b0;
        case (state_q)
            HUNT: begin
                if (rise) begin
                    state_d = ACQ;
                    bnd     = 1'b1;
                end else if (full) begin
                    bnd = 1'b1;
                end
            end
            default: begin  // ACQ, LOCK
                if (rise) begin
                    bnd = 1'b1;
                    if (full) begin
                        emit    = 1'b1;
                        state_d = LOCK;
                    end else begin
                        err     = 1'b1;
                        state_d = ACQ;
                    end
                end else if (full) begin
                    bnd = 1'b1;
                    // No rise at the frame end: either the next frame is a
                    // zero sample (emit) or the line has been stuck high.
                    if (hcnt_q < HI_FULL) begin
                        emit    = 1'b1;
                        state_d = LOCK;
                    end else begin
                        err     = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
        endcase

        // The boundary cycle already belongs to the new frame, so the high
        // count restarts from its level rather than from zero.
        cnt_d  = bnd ? '0 : cnt_q + (WIDTH+1)'(1);
        hcnt_d = bnd ? (WIDTH+1)'(lvl) : hcnt_q + (WIDTH+1)'(lvl);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            valid_o  <= emit;
            err_o    <= err;
            locked_o <= (state_q == LOCK);
        end
    end

    // Only a real reset clears the sample; disabling holds the last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_o <= '0;
        end else if (en && emit) begin
            sample_o <= hcnt_q[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod -- directed self-checking bench for pwm_demod (defaults:
// FRAME=256, WIDTH=8, SYNC_STAGES=2). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_pwm_demod;

    logic       clk, rst, en, pwm_i;
    logic [7:0] sample_o;
    logic       valid_o, locked_o, err_o;

    pwm_demod dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pwm_i    (pwm_i),
        .sample_o (sample_o),
        .valid_o  (valid_o),
        .locked_o (locked_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         nasrt = 0;
    int         nfail = 0;
    int         tcnt  = 0;
    int         errs  = 0;
    logic [7:0] vs[$];
    bit         vl[$];
    int         vt[$];
    int         tf2;
    int         fr[9] = '{100, 100, 100, 255, 1, 0, 0, 128, 100};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: record what the DUT shows, then drive the next level.
    task automatic cyc(input logic p);
        @(negedge clk);
        tcnt++;
        if (valid_o) begin
            vs.push_back(sample_o);
            vl.push_back(locked_o);
            vt.push_back(tcnt);
        end
        if (err_o) errs++;
        pwm_i = p;
    endtask

    task automatic frame(input int s);
        for (int i = 0; i < 256; i++) cyc(i < s);
    endtask

    task automatic clr_log();
        vs.delete();
        vl.delete();
        vt.delete();
        errs = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; pwm_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sample", sample_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;

        // Idle low line: never locks, never emits.
        for (int i = 0; i < 1000; i++) cyc(1'b0);
        chk("idle_nvalid", vs.size(), 0);
        chk("idle_locked", locked_o, 0);
        chk("idle_sample", sample_o, 0);
        chk("idle_nerr", errs, 0);

        // Aligned frames, including 255 and the zero/one timeout cases.
        clr_log();
        frame(fr[0]);
        tf2 = tcnt + 1;
        for (int i = 1; i < 9; i++) frame(fr[i]);
        chk("seq_nvalid", vs.size(), 8);
        chk("seq_nerr", errs, 0);
        chk("seq_latency", vt[0], tf2 + 3);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("seq_sample%0d", i), vs[i], fr[i]);
            chk($sformatf("seq_locked%0d", i), vl[i], (i > 0) ? 1 : 0);
            if (i > 0) chk($sformatf("seq_space%0d", i), vt[i] - vt[i-1], 256);
        end

        // Spurious rise at cnt=40. Its boundary puts the next real rise only
        // 216 cycles later, a second short frame, so two err pulses are due
        // before the timing is re-acquired.
        clr_log();
        for (int i = 0; i < 256; i++) cyc((i < 20) || (i >= 40 && i < 50));
        chk("spur_locked_s", locked_o, 0);
        frame(100);
        chk("spur_locked_a", locked_o, 0);
        frame(100);
        frame(100);
        chk("spur_nerr", errs, 2);
        chk("spur_nvalid", vs.size(), 3);
        chk("spur_lk0", vl[0], 1);
        chk("spur_lk1", vl[1], 0);
        chk("spur_lk2", vl[2], 1);
        chk("spur_samp1", vs[1], 100);
        chk("spur_locked_c", locked_o, 1);

        // Stuck-high line after lock.
        clr_log();
        for (int i = 0; i < 600; i++) cyc(1'b1);
        for (int i = 0; i < 300; i++) cyc(1'b0);
        chk("stuck_nerr", errs, 1);
        chk("stuck_nvalid", vs.size(), 1);
        chk("stuck_samp", vs[0], 100);
        chk("stuck_locked", locked_o, 0);

        // Relock, then reset mid-frame (line low at that point).
        clr_log();
        frame(50); frame(50); frame(50);
        for (int i = 0; i < 100; i++) cyc(i < 77);
        chk("pre_rst_nvalid", vs.size(), 3);
        chk("pre_rst_sample", sample_o, 50);
        chk("pre_rst_locked", locked_o, 1);
        rst = 1'b1;
        cyc(1'b0);
        chk("mrst_sample", sample_o, 0);
        chk("mrst_valid", valid_o, 0);
        chk("mrst_locked", locked_o, 0);
        chk("mrst_err", err_o, 0);
        rst = 1'b0;
        clr_log();
        for (int i = 0; i < 155; i++) cyc(1'b0);
        frame(60); frame(60); frame(60);
        chk("rlk_nvalid", vs.size(), 2);
        chk("rlk_samp0", vs[0], 60);
        chk("rlk_lk0", vl[0], 0);
        chk("rlk_lk1", vl[1], 1);
        chk("rlk_nerr", errs, 0);

        // Enable dropped mid-frame: sample held, everything else cleared.
        clr_log();
        for (int i = 0; i < 100; i++) cyc(i < 60);
        chk("pre_en_nvalid", vs.size(), 1);
        en = 1'b0;
        cyc(1'b0);
        chk("en_sample", sample_o, 60);
        chk("en_valid", valid_o, 0);
        chk("en_locked", locked_o, 0);
        chk("en_err", err_o, 0);
        en = 1'b1;
        clr_log();
        for (int i = 0; i < 155; i++) cyc(1'b0);
        frame(70); frame(70); frame(70);
        chk("ren_nvalid", vs.size(), 2);
        chk("ren_samp0", vs[0], 70);
        chk("ren_lk0", vl[0], 0);
        chk("ren_lk1", vl[1], 1);
        chk("ren_nerr", errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
